// File: rtl/acc_unit.sv
// 8-bit accumulator sequencing an external ripple adder through IDLE->EXEC->DONE.
// Optional build macro ACC_SAT_EN: ADD/SUB results saturate on signed overflow.
module acc_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_cmd,
  input  logic [7:0] in_data,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_op,
  input  logic [7:0] add_sum,
  input  logic       add_carry,
  input  logic       add_overflow,
  output logic [7:0] acc,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_c,
  output logic       flag_v,
  output logic       out_valid
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {CMD_LOAD = 2'b00, CMD_ADD = 2'b01, CMD_SUB = 2'b10, CMD_CLR = 2'b11} cmd_t;

  state_t     state;
  cmd_t       cmd_q;
  logic [7:0] opnd_q;

  logic [7:0] arith_res;
  logic [7:0] res;
  logic       res_c;
  logic       res_v;

  // The adder sees only registered values, so its results are stable for the whole EXEC cycle.
  assign add_a    = acc;
  assign add_b    = opnd_q;
  assign add_op   = (cmd_q == CMD_SUB);
  assign in_ready = (state == IDLE);

  always_comb begin
    arith_res = add_sum;
`ifdef ACC_SAT_EN
    if (add_overflow) begin
      arith_res = acc[7] ? 8'h80 : 8'h7F;
    end
`endif
    res   = arith_res;
    res_c = add_carry;
    res_v = add_overflow;
    case (cmd_q)
      CMD_LOAD: begin
        res   = opnd_q;
        res_c = 1'b0;
        res_v = 1'b0;
      end
      CMD_CLR: begin
        res   = 8'h00;
        res_c = 1'b0;
        res_v = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_q     <= CMD_LOAD;
      opnd_q    <= 8'h00;
      acc       <= 8'h00;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cmd_q  <= cmd_t'(in_cmd);
            opnd_q <= in_data;
            state  <= EXEC;
          end
        end
        EXEC: begin
          acc       <= res;
          flag_z    <= (res == 8'h00);
          flag_n    <= res[7];
          flag_c    <= res_c;
          flag_v    <= res_v;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit: external adder model, integer reference model,
// directed corner cases, randomized command streams, handshake and reset scenarios.
module tb_acc_unit;

  localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_cmd = 2'b00;
  logic [7:0] in_data = 8'h00;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_op, add_carry, add_overflow;
  logic [7:0] acc;
  logic       flag_z, flag_n, flag_c, flag_v, out_valid;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  int         m_acc = 0;
  logic [3:0] m_flags = 4'b0000;

  // snapshots taken by issue()
  logic [7:0] exp_a, ex_a, ex_b, dn_acc;
  logic       ex_op;
  logic [3:0] dn_flags, rdy_seq;
  logic [2:0] ov_seq;

  acc_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_data(in_data), .add_a(add_a), .add_b(add_b),
    .add_op(add_op), .add_sum(add_sum), .add_carry(add_carry),
    .add_overflow(add_overflow), .acc(acc), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // downstream ripple adder: a + b, or a + ~b + 1 for subtract
  logic [7:0] b_eff;
  logic [8:0] sum9;
  always_comb begin
    b_eff        = add_op ? ~add_b : add_b;
    sum9         = {1'b0, add_a} + {1'b0, b_eff} + {8'h00, add_op};
    add_sum      = sum9[7:0];
    add_carry    = sum9[8];
    add_overflow = (add_a[7] == b_eff[7]) && (sum9[7] != add_a[7]);
  end

  task automatic model_apply(input logic [1:0] c, input logic [7:0] d);
    int a, dv, sa, sd, full, sfull, r;
    logic cf, vf;
    a = m_acc; dv = int'(d);
    sa = (a > 127) ? a - 256 : a;
    sd = (dv > 127) ? dv - 256 : dv;
    r = 0; cf = 1'b0; vf = 1'b0;
    case (c)
      LOAD: r = dv;
      CLR:  r = 0;
      default: begin
        full  = (c == ADD) ? a + dv : a - dv;
        sfull = (c == ADD) ? sa + sd : sa - sd;
        r     = full & 255;
        cf    = (c == ADD) ? (full > 255) : (a >= dv);
        vf    = (sfull > 127) || (sfull < -128);
`ifdef ACC_SAT_EN
        if (vf) r = (sfull > 127) ? 127 : 128;
`endif
      end
    endcase
    m_acc   = r;
    m_flags = {(r == 0), (r > 127), cf, vf};
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_flags = 4'b0000;
  endtask

  // drives one command from IDLE and samples each phase at the falling edge
  task automatic issue(input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_cmd = c; in_data = d;
    rdy_seq[3] = in_ready;
    exp_a = 8'(m_acc);
    model_apply(c, d);
    @(negedge clk);
    in_valid = 1'b0;
    ex_a = add_a; ex_b = add_b; ex_op = add_op;
    rdy_seq[2] = in_ready; ov_seq[2] = out_valid;
    @(negedge clk);
    dn_acc = acc; dn_flags = {flag_z, flag_n, flag_c, flag_v};
    rdy_seq[1] = in_ready; ov_seq[1] = out_valid;
    @(negedge clk);
    rdy_seq[0] = in_ready; ov_seq[0] = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({acc, flag_z, flag_n, flag_c, flag_v, out_valid, in_ready} !== {8'h00, 4'b0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_state: acc=%h flags=%b ov=%b rdy=%b, want acc=00 flags=0000 ov=0 rdy=1",
               acc, {flag_z, flag_n, flag_c, flag_v}, out_valid, in_ready);
    end
    n_cmp++;
    if ({add_a, add_b, add_op} !== {8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_adder_ports: a=%h b=%h op=%b, want 00 00 0", add_a, add_b, add_op);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_directed();
    logic [7:0] want_acc;
    logic [3:0] want_flags;
    issue(LOAD, 8'h7F);
    issue(ADD, 8'h1F);
`ifdef ACC_SAT_EN
    want_acc = 8'h7F; want_flags = 4'b0001;
`else
    want_acc = 8'h9E; want_flags = 4'b0101;
`endif
    n_cmp++;
    if ({dn_acc, dn_flags} !== {want_acc, want_flags}) begin
      n_fail++;
      $display("[TB] FAIL add_overflow: acc=%h zncv=%b, want acc=%h zncv=%b", dn_acc, dn_flags, want_acc, want_flags);
    end
    issue(LOAD, 8'hFF);
    issue(ADD, 8'h01);
    n_cmp++;
    if ({dn_acc, dn_flags} !== {8'h00, 4'b1010}) begin
      n_fail++;
      $display("[TB] FAIL add_wrap: acc=%h zncv=%b, want acc=00 zncv=1010", dn_acc, dn_flags);
    end
    n_cmp++;
    if ({ex_a, ex_b, ex_op} !== {8'hFF, 8'h01, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL add_wrap_exec_ports: a=%h b=%h op=%b, want ff 01 0", ex_a, ex_b, ex_op);
    end
    issue(LOAD, 8'h3D);
    issue(SUB, 8'h35);
    n_cmp++;
    if ({dn_acc, dn_flags} !== {8'h08, 4'b0010} || ex_op !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sub_small: acc=%h zncv=%b op=%b, want acc=08 zncv=0010 op=1", dn_acc, dn_flags, ex_op);
    end
    issue(LOAD, 8'h87);
    issue(SUB, 8'h07);
    n_cmp++;
    if ({dn_acc, dn_flags} !== {8'h80, 4'b0110}) begin
      n_fail++;
      $display("[TB] FAIL sub_neg: acc=%h zncv=%b, want acc=80 zncv=0110", dn_acc, dn_flags);
    end
    issue(LOAD, 8'h55);
    issue(CLR, 8'hA3);
    n_cmp++;
    if ({dn_acc, dn_flags} !== {8'h00, 4'b1000}) begin
      n_fail++;
      $display("[TB] FAIL clr: acc=%h zncv=%b, want acc=00 zncv=1000", dn_acc, dn_flags);
    end
    issue(SUB, 8'h01);
    n_cmp++;
    if ({dn_acc, dn_flags} !== {8'hFF, 4'b0100}) begin
      n_fail++;
      $display("[TB] FAIL sub_borrow: acc=%h zncv=%b, want acc=ff zncv=0100", dn_acc, dn_flags);
    end
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      c = 2'($urandom_range(0, 3));
      if (c == CLR && ($urandom_range(0, 1) == 1)) c = ADD;
      d = 8'($urandom);
      issue(c, d);
      n_cmp++;
      if ({dn_acc, dn_flags} !== {8'(m_acc), m_flags}) begin
        n_fail++;
        $display("[TB] FAIL rand_result[%0d] cmd=%0d d=%h: acc=%h zncv=%b, want acc=%h zncv=%b",
                 i, c, d, dn_acc, dn_flags, 8'(m_acc), m_flags);
      end
      n_cmp++;
      if ({ex_a, ex_b, ex_op} !== {exp_a, d, (c == SUB)}) begin
        n_fail++;
        $display("[TB] FAIL rand_exec_ports[%0d]: a=%h b=%h op=%b, want %h %h %b",
                 i, ex_a, ex_b, ex_op, exp_a, d, (c == SUB));
      end
      n_cmp++;
      if ({rdy_seq, ov_seq} !== {4'b1001, 3'b010}) begin
        n_fail++;
        $display("[TB] FAIL rand_handshake[%0d]: ready=%b out_valid=%b, want ready=1001 out_valid=010",
                 i, rdy_seq, ov_seq);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] c;
    logic [7:0] d;
    int pulses;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== (k % 3 == 0)) begin
        n_fail++;
        $display("[TB] FAIL b2b_ready[%0d]: in_ready=%b, want %b", k, in_ready, (k % 3 == 0));
      end
      if (out_valid === 1'b1) pulses++;
      if (k % 3 == 2) begin
        n_cmp++;
        if ({out_valid, acc, flag_z, flag_n, flag_c, flag_v} !== {1'b1, 8'(m_acc), m_flags}) begin
          n_fail++;
          $display("[TB] FAIL b2b_commit[%0d]: ov=%b acc=%h zncv=%b, want ov=1 acc=%h zncv=%b", k, out_valid,
                   acc, {flag_z, flag_n, flag_c, flag_v}, 8'(m_acc), m_flags);
        end
      end
      c = 2'($urandom_range(0, 2));
      d = 8'($urandom);
      in_valid = 1'b1; in_cmd = c; in_data = d;
      if (k % 3 == 0) model_apply(c, d);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (pulses != 4) begin
      n_fail++;
      $display("[TB] FAIL b2b_pulse_count: got %0d out_valid cycles, want 4", pulses);
    end
  endtask

  task automatic test_reset_midflight();
    int pulses;
    issue(LOAD, 8'h42);
    @(negedge clk);
    in_valid = 1'b1; in_cmd = ADD; in_data = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({acc, flag_z, flag_n, flag_c, flag_v, out_valid, in_ready} !== {8'h00, 4'b0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_in_exec: acc=%h zncv=%b ov=%b rdy=%b, want acc=00 zncv=0000 ov=0 rdy=1",
               acc, {flag_z, flag_n, flag_c, flag_v}, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || acc !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_discard: pulses=%0d acc=%h, want pulses=0 acc=00", pulses, acc);
    end
    in_valid = 1'b1; in_cmd = LOAD; in_data = 8'h99;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, acc} !== {1'b1, 8'h99}) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_done: ov=%b acc=%h, want ov=1 acc=99", out_valid, acc);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, acc, in_ready, flag_n} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_in_done: ov=%b acc=%h rdy=%b n=%b, want ov=0 acc=00 rdy=1 n=0",
               out_valid, acc, in_ready, flag_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_unit.md
ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 SHALL have parameter: none; the data width is fixed at 8 bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a command.
REQ-006 SHALL have port in_cmd  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-007 SHALL have port in_data  input  8  operand.
REQ-008 SHALL have port add_a, add_b  output  8 each  operands driven to the downstream ripple adder.
REQ-009 SHALL have port add_op  output  1  adder operation: 0 means add, 1 means subtract (a-b).
REQ-010 SHALL have port add_sum, add_carry, add_overflow  input  8/1/1  combinational adder results.
REQ-011 SHALL have port acc  output  8  accumulator.
REQ-012 SHALL have port flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative, carry, signed overflow.
REQ-013 SHALL have port out_valid  output  1  one-cycle pulse after each commit.

Function
REQ-014 SHALL implement the FSM IDLE->EXEC->DONE->IDLE; in_ready=1 only in IDLE.
REQ-015 SHALL accept a command on the edge where in_valid&in_ready=1: in_cmd and in_data are registered, and the FSM goes IDLE->EXEC.
REQ-016 SHALL ignore in_valid in EXEC and DONE; the command is not captured and there is no side effect.
REQ-017 SHALL drive add_a=acc, add_b=operand register and add_op=(registered cmd==SUB) continuously from registers, with no combinational path from in_*.
REQ-018 SHALL commit acc and flags on the EXEC->DONE edge, 1 cycle after accept.
REQ-019 SHALL assert out_valid only in DONE; a new command is accepted no earlier than the edge 3 cycles after the previous accept.
REQ-020 ADD/SUB SHALL set acc=add_sum, flag_c=add_carry, flag_v=add_overflow, flag_z=(result==0) and flag_n=result[7]; for SUB, C=1 means no borrow.
REQ-021 LOAD SHALL set acc=in_data and update Z/N from it, and SHALL clear C and V.
REQ-022 CLR SHALL set acc=0x00, Z=1 and N=C=V=0.
REQ-023 SHALL wrap all arithmetic modulo 256, except as stated in REQ-027.
REQ-024 SHALL hold acc and flags between commits.

Reset
REQ-025 SHALL, while rst_n=0 and asynchronously, force: FSM=IDLE, acc=0x00, operand register=0x00, cmd=LOAD, all flags=0, out_valid=0; in_ready=1 after reset.
REQ-026 SHALL, when reset is asserted in EXEC or DONE, discard the pending command and produce no out_valid pulse after release.

Configuration
REQ-027 Macro ACC_SAT_EN: when defined, ADD/SUB with add_overflow=1 SHALL commit 0x7F if add_a[7]=0, or 0x80 if add_a[7]=1, with V=1, C=add_carry and Z/N computed from the saturated value; when undefined, REQ-023 wrap behaviour applies unchanged.

Verification
REQ-028 Reset: rst_n low mid-sequence -> immediately acc=0x00, flags=0000, out_valid=0, in_ready=1.
REQ-029 LOAD 0x7F, then ADD 0x1F -> acc=0x9E, N=1, V=1, C=0, Z=0 (ACC_SAT_EN: acc=0x7F, N=0, V=1).
REQ-030 LOAD 0xFF, then ADD 0x01 -> acc=0x00, Z=1, C=1, V=0, N=0; add_a=0xFF, add_b=0x01, add_op=0 during EXEC.
REQ-031 LOAD 0x3D, then SUB 0x35 -> acc=0x08, C=1, V=0; LOAD 0x87, then SUB 0x07 -> acc=0x80, N=1.
REQ-032 Handshake: in_valid held high continuously -> in_ready pattern is 1,0,0 repeating, out_valid pulses once per command, and commands presented in EXEC/DONE are not executed.
REQ-033 Reset pulse during EXEC of ADD 0x01 -> after release acc=0x00 and no out_valid pulse; CLR after LOAD 0x55 -> acc=0x00, Z=1.
